// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: syncs PS/2 done, parses E0/F0 scancode streams, queues key events.
// Optional typematic repeat filter enabled by defining KEY_REPEAT_FILTER_EN.
module ps2_key_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic [7:0]        char,
   input  logic              done,
   input  logic              ev_ready,
   output logic              ev_valid,
   output logic [7:0]        ev_code,
   output logic              ev_ext,
   output logic              ev_release,
   output logic [ADDR_W:0]   ev_count,
   output logic              overflow,
   input  logic              clr_ovf
);

   typedef enum logic [2:0] {
      IDLE, EXT, BRK, EXT_BRK, PUSH
   } state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

   logic            sync1, sync2, sync3;
   logic            strobe;
   logic [7:0]      byte_reg;
   state_t          state;
   logic [7:0]      p_code;
   logic            p_ext, p_rel;
   logic            is_pfx, is_status;
   logic            filt_drop;

   logic [9:0]        mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push_req, pop, full, wr_en, drop;
   logic [9:0]        head;

   // strobe is registered alongside byte_reg so both line up for the parser
   always_ff @(posedge CLK) begin
      if (!rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         strobe   <= 1'b0;
         byte_reg <= 8'h00;
      end else begin
         sync1  <= done;
         sync2  <= sync1;
         sync3  <= sync2;
         strobe <= sync2 & ~sync3;
         if (sync2 & ~sync3)
            byte_reg <= char;
      end
   end

   assign is_pfx    = (byte_reg == 8'hE0) || (byte_reg == 8'hF0);
   assign is_status = byte_reg inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state  <= IDLE;
         p_code <= 8'h00;
         p_ext  <= 1'b0;
         p_rel  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (strobe) begin
               if (byte_reg == 8'hE0)
                  state <= EXT;
               else if (byte_reg == 8'hF0)
                  state <= BRK;
               else if (!is_status) begin
                  state  <= PUSH;
                  p_code <= byte_reg;
                  p_ext  <= 1'b0;
                  p_rel  <= 1'b0;
               end
            end
            EXT: if (strobe) begin
               if (byte_reg == 8'hF0)
                  state <= EXT_BRK;
               else if (byte_reg != 8'hE0) begin
                  state  <= PUSH;
                  p_code <= byte_reg;
                  p_ext  <= 1'b1;
                  p_rel  <= 1'b0;
               end
            end
            BRK: if (strobe) begin
               if (is_pfx)
                  state <= IDLE;
               else begin
                  state  <= PUSH;
                  p_code <= byte_reg;
                  p_ext  <= 1'b0;
                  p_rel  <= 1'b1;
               end
            end
            EXT_BRK: if (strobe) begin
               if (is_pfx)
                  state <= IDLE;
               else begin
                  state  <= PUSH;
                  p_code <= byte_reg;
                  p_ext  <= 1'b1;
                  p_rel  <= 1'b1;
               end
            end
            PUSH:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef KEY_REPEAT_FILTER_EN
   logic       held_vld;
   logic [7:0] held_code;
   logic       held_ext;
   logic       held_match;

   assign held_match = held_vld && (held_code == p_code) &&
                       (held_ext == p_ext);
   assign filt_drop  = !p_rel && held_match;

   always_ff @(posedge CLK) begin
      if (!rst) begin
         held_vld  <= 1'b0;
         held_code <= 8'h00;
         held_ext  <= 1'b0;
      end else if (state == PUSH) begin
         if (!p_rel && !held_match) begin
            held_vld  <= 1'b1;
            held_code <= p_code;
            held_ext  <= p_ext;
         end else if (p_rel && held_match) begin
            held_vld <= 1'b0;
         end
      end
   end
`else
   assign filt_drop = 1'b0;
`endif

   assign push_req = (state == PUSH) && !filt_drop;
   assign ev_valid = (ev_count != '0);
   assign pop      = ev_valid & ev_ready;
   assign full     = (ev_count == FULL_CNT);
   assign wr_en    = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[wr_ptr] <= {p_code, p_ext, p_rel};
   end

   always_ff @(posedge CLK) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ev_count <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_W'(1);
         if (wr_en && !pop)
            ev_count <= ev_count + (ADDR_W+1)'(1);
         else if (!wr_en && pop)
            ev_count <= ev_count - (ADDR_W+1)'(1);
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   // memory is not reset, so the head is masked while the queue is empty
   assign head       = mem[rd_ptr];
   assign ev_code    = ev_valid ? head[9:2] : 8'h00;
   assign ev_ext     = ev_valid ? head[1]   : 1'b0;
   assign ev_release = ev_valid ? head[0]   : 1'b0;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer.
// Covers both builds of KEY_REPEAT_FILTER_EN.
module tb_ps2_key_sequencer;

   logic       CLK;
   logic       rst;
   logic [7:0] char;
   logic       done;
   logic       ev_ready;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic [3:0] ev_count;
   logic       overflow;
   logic       clr_ovf;

   int checks = 0;
   int errors = 0;

   ps2_key_sequencer #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
      .CLK        (CLK),
      .rst        (rst),
      .char       (char),
      .done       (done),
      .ev_ready   (ev_ready),
      .ev_valid   (ev_valid),
      .ev_code    (ev_code),
      .ev_ext     (ev_ext),
      .ev_release (ev_release),
      .ev_count   (ev_count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge CLK);
      char = b;
      done = 1'b1;
      repeat (6) @(negedge CLK);
      done = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   task automatic pop_one();
      @(negedge CLK);
      ev_ready = 1'b1;
      @(negedge CLK);
      ev_ready = 1'b0;
   endtask

   task automatic head(input string tag, input logic [7:0] code,
                       input logic ext, input logic rel);
      check({tag, "_valid"}, ev_valid, 1);
      check({tag, "_code"}, ev_code, code);
      check({tag, "_ext"}, ev_ext, ext);
      check({tag, "_rel"}, ev_release, rel);
   endtask

   logic [7:0] c;
   logic [8:0] rep_exp [4];
   int         rep_n;

   initial begin
      rst = 1'b0;
      char = 8'h00;
      done = 1'b0;
      ev_ready = 1'b0;
      clr_ovf = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_valid", ev_valid, 0);
      check("rst_count", ev_count, 0);
      check("rst_code", ev_code, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b1;

      // pending E0 must be discarded by reset
      send(8'hE0);
      rst = 1'b0;
      repeat (2) @(negedge CLK);
      check("midrst_valid", ev_valid, 0);
      check("midrst_ext", ev_ext, 0);
      check("midrst_rel", ev_release, 0);
      check("midrst_count", ev_count, 0);
      rst = 1'b1;
      send(8'h1C);
      check("midrst_cnt1", ev_count, 1);
      head("midrst", 8'h1C, 1'b0, 1'b0);
      pop_one();
      check("pop_empty", ev_count, 0);
      check("pop_valid", ev_valid, 0);

      pop_one();
      check("empty_pop", ev_count, 0);

      // latency of the final byte of E0 F0 75
      send(8'hE0);
      send(8'hF0);
      @(negedge CLK);
      char = 8'h75;
      done = 1'b1;
      repeat (4) @(negedge CLK);
      check("lat_n3", ev_valid, 0);
      @(negedge CLK);
      check("lat_n4", ev_valid, 1);
      head("extbrk", 8'h75, 1'b1, 1'b1);
      done = 1'b0;
      repeat (4) @(negedge CLK);
      pop_one();

      send(8'hAA);
      send(8'hFA);
      check("status_cnt", ev_count, 0);
      send(8'hF0);
      send(8'hF0);
      send(8'h72);
      check("f0f0_cnt", ev_count, 1);
      head("f0f0", 8'h72, 1'b0, 1'b0);
      pop_one();

      // nine makes into an eight-entry queue
      c = 8'h15;
      for (int i = 0; i < 9; i++) begin
         send(c);
         c = c + 8'h01;
      end
      check("ovf_cnt", ev_count, 8);
      check("ovf_flag", overflow, 1);
      head("ovf_head", 8'h15, 1'b0, 1'b0);
      @(negedge CLK);
      clr_ovf = 1'b1;
      @(negedge CLK);
      clr_ovf = 1'b0;
      check("clr_ovf", overflow, 0);

      // pop on the write edge while full
      @(negedge CLK);
      char = 8'h2D;
      done = 1'b1;
      repeat (4) @(negedge CLK);
      ev_ready = 1'b1;
      @(negedge CLK);
      ev_ready = 1'b0;
      check("pp_cnt", ev_count, 8);
      check("pp_ovf", overflow, 0);
      done = 1'b0;
      repeat (4) @(negedge CLK);
      c = 8'h16;
      for (int i = 0; i < 8; i++) begin
         head("drain", (i < 7) ? c : 8'h2D, 1'b0, 1'b0);
         c = c + 8'h01;
         pop_one();
      end
      check("drain_cnt", ev_count, 0);

      send(8'h1C);
      send(8'h1C);
      send(8'h1C);
      send(8'hF0);
      send(8'h1C);
`ifdef KEY_REPEAT_FILTER_EN
      rep_n = 2;
      rep_exp[0] = {8'h1C, 1'b0};
      rep_exp[1] = {8'h1C, 1'b1};
      rep_exp[2] = 9'h0;
      rep_exp[3] = 9'h0;
`else
      rep_n = 4;
      rep_exp[0] = {8'h1C, 1'b0};
      rep_exp[1] = {8'h1C, 1'b0};
      rep_exp[2] = {8'h1C, 1'b0};
      rep_exp[3] = {8'h1C, 1'b1};
`endif
      check("rep_cnt", ev_count, rep_n);
      for (int i = 0; i < rep_n; i++) begin
         head("rep", rep_exp[i][8:1], 1'b0, rep_exp[i][0]);
         pop_one();
      end
      check("rep_empty", ev_count, 0);
      check("final_ovf", overflow, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
